// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-step multiply/divide with HI/LO result registers.
// Multiply is shift-add, divide is restoring shift-subtract; both take 33 cycles
// from start-accept to result. Define MULTDIV_SIGNED_EN to make op[1] select the
// signed MULT/DIV variants; without it every operation is unsigned.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t           state_q, state_d;
   logic [4:0]       count_q;
   logic             is_div_q, b_zero_q, neg_lo_q, neg_hi_q;
   logic [WIDTH-1:0] raw_a_q, operand_q, work_hi_q, work_lo_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             done_q, dbz_q;

   // Operand magnitudes and sign flags at launch.
   logic             neg_a, neg_b;
   logic [WIDTH-1:0] mag_a, mag_b;

   // Sign-corrected results presented to HI/LO in FINISH.
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef MULTDIV_SIGNED_EN
   assign neg_a    = op[1] & src_a[WIDTH-1];
   assign neg_b    = op[1] & src_b[WIDTH-1];
   assign mag_a    = neg_a ? -src_a : src_a;
   assign mag_b    = neg_b ? -src_b : src_b;
   // Product and quotient take the XOR of the signs; remainder follows the dividend.
   assign prod_fix = neg_lo_q ? -{work_hi_q, work_lo_q} : {work_hi_q, work_lo_q};
   assign quo_fix  = neg_lo_q ? -work_lo_q : work_lo_q;
   assign rem_fix  = neg_hi_q ? -work_hi_q : work_hi_q;
`else
   logic unused_sign;
   assign neg_a       = 1'b0;
   assign neg_b       = 1'b0;
   assign mag_a       = src_a;
   assign mag_b       = src_b;
   assign prod_fix    = {work_hi_q, work_lo_q};
   assign quo_fix     = work_lo_q;
   assign rem_fix     = work_hi_q;
   assign unused_sign = op[1] ^ neg_lo_q ^ neg_hi_q;
`endif

   // One iteration: shift-add for multiply, trial subtract for divide.
   logic [WIDTH:0] mul_sum, div_shift, div_diff;
   assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, operand_q} : '0);
   assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, operand_q};

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (count_q == 5'd31) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: launch, iterate, write back, and idle-time HI/LO moves.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         is_div_q  <= 1'b0;
         b_zero_q  <= 1'b0;
         neg_lo_q  <= 1'b0;
         neg_hi_q  <= 1'b0;
         raw_a_q   <= '0;
         operand_q <= '0;
         work_hi_q <= '0;
         work_lo_q <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  count_q   <= '0;
                  is_div_q  <= op[0];
                  b_zero_q  <= (src_b == '0);
                  neg_lo_q  <= neg_a ^ neg_b;
                  neg_hi_q  <= neg_a;
                  raw_a_q   <= src_a;
                  operand_q <= op[0] ? mag_b : mag_a;
                  work_hi_q <= '0;
                  work_lo_q <= op[0] ? mag_a : mag_b;
                  dbz_q     <= 1'b0;
               end else begin
                  if (mthi) hi_q <= wdata;
                  if (mtlo) lo_q <= wdata;
               end
            end
            RUN: begin
               count_q <= count_q + 5'd1;
               if (!is_div_q) begin
                  work_hi_q <= mul_sum[WIDTH:1];
                  work_lo_q <= {mul_sum[0], work_lo_q[WIDTH-1:1]};
               end else if (!div_diff[WIDTH]) begin
                  work_hi_q <= div_diff[WIDTH-1:0];
                  work_lo_q <= {work_lo_q[WIDTH-2:0], 1'b1};
               end else begin
                  work_hi_q <= div_shift[WIDTH-1:0];
                  work_lo_q <= {work_lo_q[WIDTH-2:0], 1'b0};
               end
            end
            FINISH: begin
               done_q <= 1'b1;
               if (!is_div_q) begin
                  {hi_q, lo_q} <= prod_fix;
               end else if (b_zero_q) begin
                  hi_q  <= raw_a_q;
                  lo_q  <= '1;
                  dbz_q <= 1'b1;
               end else begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign hi          = hi_q;
   assign lo          = lo_q;
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult_div_unit, checked every cycle
// against a transaction-level model plus hand-computed literal results.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, mthi, mtlo;
   logic [1:0]  op;
   logic [31:0] src_a, src_b, wdata;
   logic [31:0] hi, lo;
   logic        busy, done, div_by_zero;

   int tests_run = 0;
   int tests_failed = 0;
   bit chk_en = 1'b0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
      end
   endtask

   // Reference result: {div_by_zero, hi, lo} from plain arithmetic.
   function automatic logic [64:0] model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
      logic   sgn;
      longint sa, sb, q, r;
      logic [63:0] p;
`ifdef MULTDIV_SIGNED_EN
      sgn = mop[1];
`else
      sgn = 1'b0;
`endif
      if (!mop[0]) begin
         if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
         else     p = {32'b0, a} * {32'b0, b};
         return {1'b0, p};
      end
      if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'b0, a});
         sb = longint'({32'b0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
   endfunction

   // Transaction model: accepted start schedules the result 33 edges later.
   logic [31:0] m_hi, m_lo;
   logic        m_dbz, m_done;
   int          m_left;
   logic [64:0] m_pend;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_hi <= '0; m_lo <= '0; m_dbz <= 1'b0; m_done <= 1'b0; m_left <= 0; m_pend <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_left == 0) begin
            if (start) begin
               m_left <= 33;
               m_pend <= model(op, src_a, src_b);
               m_dbz  <= 1'b0;
            end else begin
               if (mthi) m_hi <= wdata;
               if (mtlo) m_lo <= wdata;
            end
         end else begin
            if (m_left == 1) begin
               m_dbz  <= m_pend[64];
               m_hi   <= m_pend[63:32];
               m_lo   <= m_pend[31:0];
               m_done <= 1'b1;
            end
            m_left <= m_left - 1;
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en && !reset) begin
         check("busy", 64'(busy), 64'(m_left != 0));
         check("done", 64'(done), 64'(m_done));
         check("hi", 64'(hi), 64'(m_hi));
         check("lo", 64'(lo), 64'(m_lo));
         check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
      end
   end

   // Drive a start for one cycle; returns at the first negedge after accept.
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; src_a = a; src_b = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for done; idx counts negedges since accept, done expected at 34.
   task automatic wait_done(input int first_idx);
      int idx = first_idx;
      while (!done && idx < 80) begin
         @(negedge clk);
         idx++;
      end
      check("latency", 64'(idx), 64'd34);
   endtask

   task automatic check_result(input string name, input logic [31:0] ehi, input logic [31:0] elo);
      check({name, "_hi"}, 64'(hi), 64'(ehi));
      check({name, "_lo"}, 64'(lo), 64'(elo));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_dbz", 64'(div_by_zero), 64'd0);
      chk_en = 1'b1;

      // MULTU max x max
      launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(1);
      check_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
      check("multu_busy_low", 64'(busy), 64'd0);

      // DIVU 100/7, then back-to-back 9/3 issued in the done cycle
      launch(2'b01, 32'd100, 32'd7);
      wait_done(1);
      check_result("divu_100_7", 32'd2, 32'd14);
      check("divu_dbz", 64'(div_by_zero), 64'd0);
      launch(2'b01, 32'd9, 32'd3);
      wait_done(1);
      check_result("divu_b2b", 32'd0, 32'd3);

      // Divide by zero, flag held until the next accepted start
      launch(2'b01, 32'h1234, 32'd0);
      wait_done(1);
      check_result("div0", 32'h1234, 32'hFFFF_FFFF);
      check("div0_flag", 64'(div_by_zero), 64'd1);
      repeat (3) @(negedge clk);
      check("div0_held", 64'(div_by_zero), 64'd1);
      launch(2'b00, 32'd2, 32'd3);
      check("div0_clear", 64'(div_by_zero), 64'd0);
      wait_done(1);
      check_result("multu_2_3", 32'd0, 32'd6);

      // Signed cases (or their unsigned interpretation)
      launch(2'b10, 32'hFFFF_FFFD, 32'd5);
      wait_done(1);
`ifdef MULTDIV_SIGNED_EN
      check_result("mult_neg3_5", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
`else
      check_result("mult_neg3_5", 32'd4, 32'hFFFF_FFF1);
`endif
      launch(2'b11, 32'hFFFF_FFF9, 32'd2);
      wait_done(1);
`ifdef MULTDIV_SIGNED_EN
      check_result("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
      check_result("div_neg7_2", 32'd1, 32'h7FFF_FFFC);
`endif
      launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(1);
`ifdef MULTDIV_SIGNED_EN
      check_result("div_min_m1", 32'd0, 32'h8000_0000);
`else
      check_result("div_min_m1", 32'h8000_0000, 32'd0);
`endif
      launch(2'b11, 32'd7, 32'hFFFF_FFFE);
      wait_done(1);

      // mthi and a second start during RUN are ignored
      launch(2'b00, 32'h0001_0000, 32'h0001_0000);
      repeat (2) @(negedge clk);
      mthi = 1'b1; wdata = 32'hAAAA; start = 1'b1; op = 2'b01; src_a = 32'd5; src_b = 32'd1;
      @(negedge clk);
      mthi = 1'b0; start = 1'b0;
      wait_done(4);
      check_result("busy_protect", 32'd1, 32'd0);

      // mtlo while idle
      mtlo = 1'b1; wdata = 32'h55;
      @(negedge clk);
      mtlo = 1'b0;
      check_result("mtlo_idle", 32'd1, 32'h55);

      // start and mthi together: start wins
      mthi = 1'b1; wdata = 32'hDEAD;
      launch(2'b00, 32'd2, 32'd3);
      mthi = 1'b0;
      wait_done(1);
      check_result("start_mthi", 32'd0, 32'd6);

      // Reset during RUN aborts immediately; next op completes normally
      launch(2'b00, 32'd7, 32'd9);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check_result("abort", 32'd0, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      launch(2'b00, 32'd7, 32'd9);
      wait_done(1);
      check_result("after_abort", 32'd0, 32'd63);

      repeat (2) @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with HI/LO result registers for the single-cycle MIPS datapath. It consumes `read_data1`/`read_data2` from the register block, computes a 64-bit product or a 32-bit quotient/remainder over 32 iterations, and holds the results in HI/LO. The control unit then reads those results back via `mfhi`/`mflo` into the register block's write-data path. It lets the core keep `mult`/`div` off the single-cycle critical path.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk` input 1: clock, rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: launch operation; sampled only when `busy`=0.
- `op` input 2: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- `src_a` input WIDTH: multiplicand/dividend (from `read_data1`).
- `src_b` input WIDTH: multiplier/divisor (from `read_data2`).
- `mthi` input 1: load HI from `wdata`.
- `mtlo` input 1: load LO from `wdata`.
- `wdata` input WIDTH: data for `mthi`/`mtlo`.
- `hi` output WIDTH: product upper half / remainder.
- `lo` output WIDTH: product lower half / quotient.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse; HI/LO valid.
- `div_by_zero` output 1: last DIV/DIVU had divisor 0.

## Operation
- FSM states:
  - IDLE: `start`=1 latches operands and op, clears the iteration counter, and moves to RUN.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. A 5-bit counter runs 0..31; on count 31 the FSM moves to FINISH.
  - FINISH: applies sign correction, writes HI/LO, pulses `done`, and returns to IDLE.
- Multiply: {HI,LO} = full 2·WIDTH-bit product.
- Divide: LO = quotient, HI = remainder.
- Signed ops: operands are converted to magnitudes at launch and signs are restored in FINISH.
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - -2^31 / -1 gives LO=0x80000000, HI=0.
- Divisor 0 (either divide):
  - The iterations still run for the full 32 cycles.
  - Result is HI=`src_a`, LO=0xFFFFFFFF.
  - `div_by_zero`=1, held until the next accepted `start`.
- `mthi`/`mtlo` take effect only when `busy`=0.
  - If asserted together, both registers load `wdata`.
  - If `start` is asserted in the same cycle, `start` wins and `mthi`/`mtlo` are ignored.
- `start` while `busy`=1 is ignored; in-flight operands are not disturbed.
- HI/LO keep their previous values during RUN and change only in FINISH or on an `mthi`/`mtlo` write.
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0, FSM=IDLE, counter=0.
- Reset asserted mid-operation aborts immediately to these values. No partial result is written.

## Timing
- Let `start` be accepted at rising edge E:
  - `busy`=1 from E through edge E+33.
  - HI/LO update at edge E+33.
  - `done`=1 for the cycle after edge E+33.
  - `busy` falls at edge E+33.
- Latency is 33 cycles, start-accept to result, for every op including divide by zero.
- Back-to-back: a `start` in the cycle where `done`=1 is accepted at the next edge.
- `mthi`/`mtlo` writes land at the edge where they are sampled and are visible next cycle.
- Outputs are all registered; there is no combinational input-to-output path.

## Configuration
- `MULTDIV_SIGNED_EN` defined: `op[1]` selects signed MULT/DIV as described above.
- Not defined:
  - `op[1]` is ignored and all operations are unsigned (MULT behaves as MULTU, DIV as DIVU).
  - Sign-correction logic is removed.
  - Latency stays 33 cycles.

## Test plan
- MULTU: 0xFFFFFFFF × 0xFFFFFFFF, start at edge E → `done` after E+33, HI=0xFFFFFFFE, LO=0x00000001, `busy` low after E+33.
- DIVU: 100 / 7 → LO=14, HI=2, `div_by_zero`=0. A `start` issued in the `done` cycle for 9 / 3 gives LO=3, HI=0 thirty-three cycles later.
- Divide by zero: DIVU 0x1234 / 0 → HI=0x1234, LO=0xFFFFFFFF, `div_by_zero`=1, held until next start.
- With `MULTDIV_SIGNED_EN`, each case checked for its result:
  - MULT -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - Without the macro, DIV -7 / 2 → LO=0x7FFFFFFC, HI=1.
- Protection while busy: `mthi` with 0xAAAA and a second `start` during RUN are both ignored and the result is unchanged. `mtlo` 0x55 while idle gives LO=0x55 next cycle. `start`+`mthi` in the same idle cycle leaves `mthi` ignored.
- Reset at RUN cycle 10 → `busy`/`done`=0 and HI/LO=0 immediately. The next `start` completes normally in 33 cycles.
